// File: rtl/imem_loader.sv
// Program loader: collects a one-byte word-count header and big-endian 32-bit
// instructions from the RX FIFO, writes them to imem and holds the CPU in reset until done.
module imem_loader #(
    parameter int MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic        start,
    output logic [31:0] data_out,
    output logic [7:0]  dir,
    output logic        we,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_rst
);

    typedef enum logic [2:0] {
        S_HDR,
        S_LOAD,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [8:0] MAX_N = 9'(MAX_WORDS);

    state_t      state, state_n;
    logic [7:0]  n;
    logic [7:0]  word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] word;
    logic        xfer;
    logic        hdr_bad;
    logic        last_word;

    assign xfer      = byte_valid & byte_ready;
    assign hdr_bad   = (byte_data == 8'd0) || ({1'b0, byte_data} > MAX_N);
    assign last_word = (word_idx == n - 8'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_HDR;
        end else begin
            // NOTE: every sequential assignment uses <= so all registers update
            // from the same pre-edge values, independent of statement order.
            state <= state_n;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case; a missed branch
        // would otherwise infer a latch.
        state_n    = state;
        byte_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        cpu_rst    = 1'b1;
        case (state)
            S_HDR: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (xfer) state_n = hdr_bad ? S_ERR : S_LOAD;
            end
            S_LOAD: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (xfer && byte_cnt == 2'd3) state_n = S_WRITE;
            end
            S_WRITE: begin
                busy    = 1'b1;
                state_n = last_word ? S_DONE : S_LOAD;
            end
            S_DONE: begin
                done    = 1'b1;
                cpu_rst = 1'b0;
            end
            S_ERR: begin
                err = 1'b1;
            end
            default: state_n = S_HDR;
        endcase
        // Restart wins over any concurrent transfer; that byte is dropped.
        if (start) state_n = S_HDR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n        <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            word     <= '0;
            data_out <= '0;
            dir      <= '0;
            we       <= 1'b0;
        end else begin
            we <= 1'b0;
            if (start) begin
                n        <= '0;
                word_idx <= '0;
                byte_cnt <= '0;
            end else begin
                case (state)
                    S_HDR: begin
                        if (xfer) begin
                            n        <= byte_data;
                            word_idx <= '0;
                            byte_cnt <= '0;
                        end
                    end
                    S_LOAD: begin
                        if (xfer) begin
                            word     <= {word[15:0], byte_data};
                            byte_cnt <= byte_cnt + 2'd1;
                            // The strobe is launched on the 4th byte so it is high for the WRITE cycle.
                            if (byte_cnt == 2'd3) begin
                                we       <= 1'b1;
                                data_out <= {word, byte_data};
                                dir      <= word_idx << 2;
                            end
                        end
                    end
                    S_WRITE: begin
                        if (!last_word) begin
                            word_idx <= word_idx + 8'd1;
                            byte_cnt <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed programs plus randomized
// programs compared against a byte-list model of the expected imem writes.
module tb_imem_loader;

    localparam int MAX_WORDS = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_ready;
    logic        start;
    logic [31:0] data_out;
    logic [7:0]  dir;
    logic        we;
    logic        busy;
    logic        done;
    logic        err;
    logic        cpu_rst;

    int tests  = 0;
    int failed = 0;

    logic [7:0]  wr_dir[$];
    logic [31:0] wr_data[$];

    imem_loader #(.MAX_WORDS(MAX_WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .byte_data (byte_data),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .start     (start),
        .data_out  (data_out),
        .dir       (dir),
        .we        (we),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .cpu_rst   (cpu_rst)
    );

    always #5 clk = ~clk;

    // Write monitor: logs every imem write and checks the FIFO is not popped meanwhile.
    always @(posedge clk) begin
        #1;
        if (we === 1'b1) begin
            wr_dir.push_back(dir);
            wr_data.push_back(data_out);
            tests++;
            if (byte_ready !== 1'b0) begin
                $display("FAIL write_ready: byte_ready=%b required 0", byte_ready);
                failed++;
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
        $fatal(1, "watchdog");
    end

    // Presents one byte and returns at the edge on which it transfers.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        @(negedge clk);
        byte_data  = b;
        byte_valid = 1'b1;
        while (byte_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        tests++;
        if (byte_ready !== 1'b1) begin
            $display("FAIL send_timeout: byte_ready=%b required 1", byte_ready);
            failed++;
        end
        @(posedge clk);
        #1 byte_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic v, input logic [7:0] d);
        @(negedge clk);
        start      = 1'b1;
        byte_valid = v;
        byte_data  = d;
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        #12;
        tests++;
        if ({byte_ready, we, busy, done, err, cpu_rst} !== 6'b101001 ||
            data_out !== 32'h0 || dir !== 8'h00) begin
            $display("FAIL reset_values: rdy/we/busy/done/err/cpu_rst=%b data=%h dir=%h required 101001 0 0",
                     {byte_ready, we, busy, done, err, cpu_rst}, data_out, dir);
            failed++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] prog[9] = '{8'h02, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h01, 8'h13};
        wr_dir.delete();
        wr_data.delete();
        foreach (prog[i]) send_byte(prog[i]);
        @(negedge clk);
        tests++;
        if (we !== 1'b1 || byte_ready !== 1'b0 || done !== 1'b0) begin
            $display("FAIL basic_write_cycle: we=%b rdy=%b done=%b required 1 0 0", we, byte_ready, done);
            failed++;
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || busy !== 1'b0 || we !== 1'b0 || byte_ready !== 1'b0) begin
            $display("FAIL basic_done: done=%b cpu_rst=%b busy=%b we=%b rdy=%b required 1 0 0 0 0",
                     done, cpu_rst, busy, we, byte_ready);
            failed++;
        end
        tests++;
        if (wr_data.size() !== 2) begin
            $display("FAIL basic_count: writes=%0d required 2", wr_data.size());
            failed++;
        end else begin
            tests++;
            if (wr_data[0] !== 32'h00500093 || wr_dir[0] !== 8'h00 ||
                wr_data[1] !== 32'h00A00113 || wr_dir[1] !== 8'h04) begin
                $display("FAIL basic_words: got %h@%h %h@%h required 00500093@00 00a00113@04",
                         wr_data[0], wr_dir[0], wr_data[1], wr_dir[1]);
                failed++;
            end
        end
    endtask

    task automatic test_bad_header();
        logic [7:0] hdrs[4];
        hdrs[0] = 8'h00;
        hdrs[1] = 8'h41;
        hdrs[2] = 8'($urandom_range(66, 255));
        hdrs[3] = 8'hFF;
        foreach (hdrs[i]) begin
            pulse_start(1'b0, 8'h00);
            wr_data.delete();
            wr_dir.delete();
            send_byte(hdrs[i]);
            @(negedge clk);
            byte_valid = 1'b1;
            byte_data  = 8'h55;
            repeat (3) @(negedge clk);
            tests++;
            if (err !== 1'b1 || cpu_rst !== 1'b1 || byte_ready !== 1'b0 || busy !== 1'b0 ||
                done !== 1'b0 || wr_data.size() !== 0) begin
                $display("FAIL bad_header_%h: err=%b cpu_rst=%b rdy=%b busy=%b done=%b writes=%0d required 1 1 0 0 0 0",
                         hdrs[i], err, cpu_rst, byte_ready, busy, done, wr_data.size());
                failed++;
            end
            byte_valid = 1'b0;
        end
    endtask

    task automatic test_random_program(input int n);
        logic [7:0]  bytes[$];
        logic [31:0] exp_word;
        int          bad = 0;
        pulse_start(1'b0, 8'h00);
        wr_data.delete();
        wr_dir.delete();
        for (int i = 0; i < 4 * n; i++) bytes.push_back(8'($urandom_range(0, 255)));
        send_byte(8'(n));
        foreach (bytes[i]) send_byte(bytes[i]);
        repeat (2) @(negedge clk);
        tests++;
        if (done !== 1'b1 || cpu_rst !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL rand_done_n%0d: done=%b cpu_rst=%b busy=%b required 1 0 0", n, done, cpu_rst, busy);
            failed++;
        end
        tests++;
        if (wr_data.size() !== n) begin
            $display("FAIL rand_count_n%0d: writes=%0d required %0d", n, wr_data.size(), n);
            failed++;
        end else begin
            for (int w = 0; w < n; w++) begin
                exp_word = {bytes[4*w], bytes[4*w+1], bytes[4*w+2], bytes[4*w+3]};
                if (bad == 0 && (wr_data[w] !== exp_word || wr_dir[w] !== 8'(4 * w))) begin
                    $display("FAIL rand_word_n%0d_w%0d: got %h@%h required %h@%h",
                             n, w, wr_data[w], wr_dir[w], exp_word, 8'(4 * w));
                    bad = 1;
                end
            end
            tests++;
            failed += bad;
        end
    endtask

    task automatic test_stall();
        pulse_start(1'b0, 8'h00);
        wr_data.delete();
        wr_dir.delete();
        send_byte(8'h01);
        send_byte(8'hDE);
        send_byte(8'hAD);
        repeat (10) @(negedge clk);
        tests++;
        if (wr_data.size() !== 0 || busy !== 1'b1 || byte_ready !== 1'b1 || we !== 1'b0) begin
            $display("FAIL stall_hold: writes=%0d busy=%b rdy=%b we=%b required 0 1 1 0",
                     wr_data.size(), busy, byte_ready, we);
            failed++;
        end
        send_byte(8'hBE);
        send_byte(8'hEF);
        repeat (2) @(negedge clk);
        tests++;
        if (wr_data.size() !== 1 || wr_data[0] !== 32'hDEADBEEF || wr_dir[0] !== 8'h00 || done !== 1'b1) begin
            $display("FAIL stall_result: writes=%0d data=%h dir=%h done=%b required 1 deadbeef 00 1",
                     wr_data.size(), wr_data.size() > 0 ? wr_data[0] : 32'h0,
                     wr_dir.size() > 0 ? wr_dir[0] : 8'h0, done);
            failed++;
        end
    endtask

    task automatic test_restart();
        logic [7:0] first[6] = '{8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        logic [7:0] second[5] = '{8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        pulse_start(1'b0, 8'h00);
        wr_data.delete();
        wr_dir.delete();
        foreach (first[i]) send_byte(first[i]);
        @(negedge clk);
        tests++;
        if (wr_data.size() !== 1 || wr_data[0] !== 32'h01020304) begin
            $display("FAIL restart_partial: writes=%0d required 1 of 01020304", wr_data.size());
            failed++;
        end
        // Byte offered with start must be discarded, not taken as a header.
        pulse_start(1'b1, 8'h7F);
        wr_data.delete();
        wr_dir.delete();
        tests++;
        if (busy !== 1'b1 || byte_ready !== 1'b1 || err !== 1'b0 || cpu_rst !== 1'b1) begin
            $display("FAIL restart_state: busy=%b rdy=%b err=%b cpu_rst=%b required 1 1 0 1",
                     busy, byte_ready, err, cpu_rst);
            failed++;
        end
        foreach (second[i]) send_byte(second[i]);
        repeat (2) @(negedge clk);
        tests++;
        if (wr_data.size() !== 1 || wr_data[0] !== 32'h11223344 || wr_dir[0] !== 8'h00 || done !== 1'b1) begin
            $display("FAIL restart_result: writes=%0d data=%h dir=%h done=%b required 1 11223344 00 1",
                     wr_data.size(), wr_data.size() > 0 ? wr_data[0] : 32'h0,
                     wr_dir.size() > 0 ? wr_dir[0] : 8'h0, done);
            failed++;
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] prog[5] = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        pulse_start(1'b0, 8'h00);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({byte_ready, we, busy, done, err, cpu_rst} !== 6'b101001 ||
            data_out !== 32'h0 || dir !== 8'h00) begin
            $display("FAIL async_reset: rdy/we/busy/done/err/cpu_rst=%b data=%h dir=%h required 101001 0 0",
                     {byte_ready, we, busy, done, err, cpu_rst}, data_out, dir);
            failed++;
        end
        @(negedge clk);
        rst = 1'b0;
        wr_data.delete();
        wr_dir.delete();
        foreach (prog[i]) send_byte(prog[i]);
        repeat (2) @(negedge clk);
        tests++;
        if (wr_data.size() !== 1 || wr_data[0] !== 32'hAABBCCDD || wr_dir[0] !== 8'h00 || done !== 1'b1) begin
            $display("FAIL async_reset_reload: writes=%0d data=%h dir=%h done=%b required 1 aabbccdd 00 1",
                     wr_data.size(), wr_data.size() > 0 ? wr_data[0] : 32'h0,
                     wr_dir.size() > 0 ? wr_dir[0] : 8'h0, done);
            failed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_header();
        test_random_program(MAX_WORDS);
        test_random_program(int'($urandom_range(1, 8)));
        test_random_program(1);
        test_stall();
        test_restart();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
